// File: rtl/regfile_writeback.sv
// Write-side controller for the integer register file: merges ALU and load results onto one write
// port and tracks pending writes in a busy scoreboard. Optional forwarding ports: `define WB_FWD_EN.
module regfile_writeback #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int LQ_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  input  logic [AW-1:0]         iss_rs1,
  input  logic [AW-1:0]         iss_rs2,
  output logic                  stall,
  input  logic                  alu_valid,
  input  logic [AW-1:0]         alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [AW-1:0]         ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  output logic                  wrt_en,
  output logic [AW-1:0]         oprd,
  output logic [XLEN-1:0]       wrt_data,
`ifdef WB_FWD_EN
  output logic                  fwd_rs1_en,
  output logic                  fwd_rs2_en,
  output logic [XLEN-1:0]       fwd_data,
`endif
  output logic [(1<<AW)-1:0]    busy
);

  localparam int NREG = 1 << AW;
  localparam int PW   = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW   = $clog2(LQ_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(LQ_DEPTH);

  logic [NREG-1:0] busy_q, busy_d;
  logic [AW-1:0]   lq_rd_q   [LQ_DEPTH];
  logic [AW-1:0]   lq_rd_d   [LQ_DEPTH];
  logic [XLEN-1:0] lq_data_q [LQ_DEPTH];
  logic [XLEN-1:0] lq_data_d [LQ_DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wrt_en_q, wrt_en_d;
  logic [AW-1:0]   oprd_q, oprd_d;
  logic [XLEN-1:0] wrt_data_q, wrt_data_d;

  logic lq_full, lq_empty, lq_push, lq_pop, alu_sel;
  logic inflight, hazard, iss_accept;

  assign lq_full  = (cnt_q == FULL_CNT);
  assign lq_empty = (cnt_q == '0);
  assign ld_ready = ~lq_full;

  // rd==0 results never occupy the write port or the load buffer
  assign alu_sel  = alu_valid & (alu_rd != '0);
  assign lq_push  = ld_valid & ~lq_full & (ld_rd != '0);
  assign lq_pop   = ~alu_sel & ~lq_empty;

  assign inflight = wrt_en_q & ((oprd_q == iss_rs1) | (oprd_q == iss_rs2));

`ifdef WB_FWD_EN
  // The value on the write port is forwarded, so it no longer blocks issue.
  assign hazard     = busy_q[iss_rs1] | busy_q[iss_rs2] | busy_q[iss_rd];
  assign fwd_rs1_en = wrt_en_q & (oprd_q == iss_rs1) & (iss_rs1 != '0);
  assign fwd_rs2_en = wrt_en_q & (oprd_q == iss_rs2) & (iss_rs2 != '0);
  assign fwd_data   = wrt_data_q;
`else
  assign hazard     = busy_q[iss_rs1] | busy_q[iss_rs2] | busy_q[iss_rd] | inflight;
`endif

  assign stall      = iss_valid & hazard;
  assign iss_accept = iss_valid & ~stall;

  always_comb begin
    lq_rd_d   = lq_rd_q;
    lq_data_d = lq_data_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q + CW'(lq_push) - CW'(lq_pop);
    if (lq_push) begin
      lq_rd_d[wptr_q]   = ld_rd;
      lq_data_d[wptr_q] = ld_data;
      wptr_d            = wptr_q + PW'(1);
    end
    if (lq_pop) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  always_comb begin
    wrt_en_d   = alu_sel | lq_pop;
    oprd_d     = oprd_q;
    wrt_data_d = wrt_data_q;
    if (alu_sel) begin
      oprd_d     = alu_rd;
      wrt_data_d = alu_data;
    end else if (lq_pop) begin
      oprd_d     = lq_rd_q[rptr_q];
      wrt_data_d = lq_data_q[rptr_q];
    end
  end

  // Clear first so that a same-edge set of the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (wrt_en_d) begin
      busy_d[oprd_d] = 1'b0;
    end
    if (iss_accept && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      wrt_en_q   <= 1'b0;
      oprd_q     <= '0;
      wrt_data_q <= '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_rd_q[i]   <= '0;
        lq_data_q[i] <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      wrt_en_q   <= wrt_en_d;
      oprd_q     <= oprd_d;
      wrt_data_q <= wrt_data_d;
      lq_rd_q    <= lq_rd_d;
      lq_data_q  <= lq_data_d;
    end
  end

  assign wrt_en   = wrt_en_q;
  assign oprd     = oprd_q;
  assign wrt_data = wrt_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: a cycle-by-cycle vector table plus hand sequences for
// reset after traffic and the RAW stall / write-port cycle.
module tb_regfile_writeback;

`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic        stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        wrt_en;
  logic [4:0]  oprd;
  logic [31:0] wrt_data;
  logic [31:0] busy;
`ifdef WB_FWD_EN
  logic        fwd_rs1_en, fwd_rs2_en;
  logic [31:0] fwd_data;
`endif

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .stall(stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .wrt_en(wrt_en), .oprd(oprd), .wrt_data(wrt_data),
`ifdef WB_FWD_EN
    .fwd_rs1_en(fwd_rs1_en), .fwd_rs2_en(fwd_rs2_en), .fwd_data(fwd_data),
`endif
    .busy(busy)
  );

  typedef struct {
    logic        iv;
    logic [4:0]  ird, rs1, rs2;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        e_stall, e_rdy, e_wen;
    logic [4:0]  e_oprd;
    logic [31:0] e_wdata, e_busy;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(
      input logic iv, input logic [4:0] ird, rs1, rs2,
      input logic av, input logic [4:0] ard, input logic [31:0] adata,
      input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
      input logic e_stall, e_rdy, e_wen, input logic [4:0] e_oprd,
      input logic [31:0] e_wdata, e_busy);
    vec_t v;
    v.iv = iv; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
    v.av = av; v.ard = ard; v.adata = adata;
    v.lv = lv; v.lrd = lrd; v.ldata = ldata;
    v.e_stall = e_stall; v.e_rdy = e_rdy; v.e_wen = e_wen;
    v.e_oprd = e_oprd; v.e_wdata = e_wdata; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic idle_inputs();
    iss_valid = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Row layout: issue | alu | load | expected stall, ld_ready, wrt_en, oprd, wrt_data, busy.
    vecs[0]  = mk(1,5,0,0, 0,0,0,            0,0,0,          0,1,0,0,0,0);
    vecs[1]  = mk(0,0,0,0, 1,5,32'hDEADBEEF, 0,0,0,          0,1,0,0,0,32'h20);
    vecs[2]  = mk(0,0,0,0, 0,0,0,            0,0,0,          0,1,1,5,32'hDEADBEEF,0);
    vecs[3]  = mk(0,0,0,0, 1,1,32'h11,       1,2,32'h22,     0,1,0,5,32'hDEADBEEF,0);
    vecs[4]  = mk(0,0,0,0, 0,0,0,            0,0,0,          0,1,1,1,32'h11,0);
    vecs[5]  = mk(0,0,0,0, 0,0,0,            0,0,0,          0,1,1,2,32'h22,0);
    vecs[6]  = mk(0,0,0,0, 1,10,32'hA0,      1,20,32'h200,   0,1,0,2,32'h22,0);
    vecs[7]  = mk(0,0,0,0, 1,11,32'hA1,      1,21,32'h201,   0,1,1,10,32'hA0,0);
    vecs[8]  = mk(0,0,0,0, 1,12,32'hA2,      1,22,32'h202,   0,0,1,11,32'hA1,0);
    vecs[9]  = mk(0,0,0,0, 1,13,32'hA3,      1,22,32'h202,   0,0,1,12,32'hA2,0);
    vecs[10] = mk(0,0,0,0, 0,0,0,            1,22,32'h202,   0,0,1,13,32'hA3,0);
    vecs[11] = mk(0,0,0,0, 0,0,0,            1,22,32'h202,   0,1,1,20,32'h200,0);
    vecs[12] = mk(0,0,0,0, 0,0,0,            0,0,0,          0,1,1,21,32'h201,0);
    vecs[13] = mk(1,9,0,0, 0,0,0,            0,0,0,          0,1,1,22,32'h202,0);
    vecs[14] = mk(0,0,0,0, 1,0,32'h55,       1,0,32'h66,     0,1,0,22,32'h202,32'h200);
    vecs[15] = mk(0,0,0,0, 0,0,0,            0,0,0,          0,1,0,22,32'h202,32'h200);
    vecs[16] = mk(1,0,9,0, 1,9,32'h99,       0,0,0,          1,1,0,22,32'h202,32'h200);
    vecs[17] = mk(1,0,9,0, 0,0,0,            0,0,0,          !FWD,1,1,9,32'h99,0);
    vecs[18] = mk(1,6,0,0, 1,6,32'h66,       0,0,0,          0,1,0,9,32'h99,0);
    vecs[19] = mk(0,0,0,0, 0,0,0,            0,0,0,          0,1,1,6,32'h66,32'h40);

    // Reset in the middle of random traffic, checked while held and after release.
    do_reset();
    for (int c = 0; c < 30; c++) begin
      iss_valid = 1'($urandom); iss_rd = 5'($urandom); iss_rs1 = 5'($urandom); iss_rs2 = 5'($urandom);
      alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = $urandom;
      ld_valid = 1'($urandom); ld_rd = 5'($urandom); ld_data = $urandom;
      next_cycle();
    end
    #2 rst_n = 0;
    #1;
    chk("rst_async_wrt_en", wrt_en, 0);
    chk("rst_async_busy", busy, 0);
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wrt_en", wrt_en, 0);
    chk("rst_oprd", oprd, 0);
    chk("rst_wrt_data", wrt_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ld_ready", ld_ready, 1);
    next_cycle();
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_no_write", wrt_en, 0);
      next_cycle();
    end

    // Table-driven stream.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      iss_valid = vecs[i].iv; iss_rd = vecs[i].ird; iss_rs1 = vecs[i].rs1; iss_rs2 = vecs[i].rs2;
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adata;
      ld_valid = vecs[i].lv; ld_rd = vecs[i].lrd; ld_data = vecs[i].ldata;
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
      chk($sformatf("v%0d_ld_ready", i), ld_ready, vecs[i].e_rdy);
      chk($sformatf("v%0d_wrt_en", i), wrt_en, vecs[i].e_wen);
      chk($sformatf("v%0d_oprd", i), oprd, vecs[i].e_oprd);
      chk($sformatf("v%0d_wrt_data", i), wrt_data, vecs[i].e_wdata);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      next_cycle();
    end

    // RAW hazard on x3 held across the busy window and the write-port cycle.
    do_reset();
    iss_valid = 1; iss_rd = 3; iss_rs1 = 0; iss_rs2 = 0;
    @(negedge clk);
    chk("raw_issue_stall", stall, 0);
    next_cycle();
    iss_rd = 7; iss_rs1 = 3;
    @(negedge clk);
    chk("raw_busy_stall_a", stall, 1);
    chk("raw_busy3", busy, 32'h8);
    next_cycle();
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    @(negedge clk);
    chk("raw_busy_stall_b", stall, 1);
    next_cycle();
    alu_valid = 0;
    @(negedge clk);
    chk("raw_wport_stall", stall, !FWD);
    chk("raw_wport_wrt_en", wrt_en, 1);
    chk("raw_wport_oprd", oprd, 3);
    chk("raw_wport_busy", busy, 0);
`ifdef WB_FWD_EN
    chk("raw_fwd_rs1_en", fwd_rs1_en, 1);
    chk("raw_fwd_rs2_en", fwd_rs2_en, 0);
    chk("raw_fwd_data", fwd_data, 32'h33);
`endif
    next_cycle();
    @(negedge clk);
    // With forwarding the instruction issued last cycle, so x7 is now busy and blocks it again.
    chk("raw_after_stall", stall, FWD);
    chk("raw_after_busy", busy, FWD ? 32'h80 : 32'h0);
    next_cycle();
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
